eth_pcs_rx_descrambler: RTL
===========================

Name: eth_pcs_rx_descrambler

Overview:
Sits directly downstream of the PCS RX gearbox. It consumes the gearbox's header and W_DATA-wide data stream and self-synchronously descrambles the payload with polynomial 1 + x^39 + x^58 (IEEE 802.3 cl.49). It reassembles each header plus descrambled payload into one 66b block (2b sync header + 64b payload) for the RX decoder. It also flags malformed blocks and block-boundary misalignment.

Parameters:
W_DATA, 32, gearbox word width; must divide W_BLK exactly.
W_SYNC, 2, sync header width.
W_BLK, 64, block payload width.
WORDS_PER_BLK, W_BLK/W_DATA, derived; number of data words per block.

Ports:
i_clk  in  1  clock.
i_reset  in  1  synchronous, active-high reset.
i_rx_lock  in  1  block lock from block sync; low forces resynchronisation of assembly.
i_grbx_hdr_valid  in  1  i_grbx_hdr carries the header of the next block.
i_grbx_hdr  in  W_SYNC  sync header; bit 0 is the first received bit.
i_grbx_data_valid  in  1  i_grbx_data carries W_DATA scrambled payload bits.
i_grbx_data  in  W_DATA  scrambled payload; bit 0 is the first received bit.
o_blk_valid  out  1  one-cycle pulse; block outputs are valid.
o_blk_hdr  out  W_SYNC  sync header of the block.
o_blk_data  out  W_BLK  descrambled payload; bit 0 is the first received bit.
o_blk_hdr_err  out  1  qualified by o_blk_valid; header is 2'b00 or 2'b11.
o_align_err  out  1  one-cycle pulse; partial block discarded.

Behaviour:
- Reset: descrambler state (58b) = 0; FSM = IDLE; word index = 0; all outputs = 0.
- Descrambler:
  - Serial view: out[n] = in[n] ^ in[n-39] ^ in[n-58], where in[] is the received scrambled bit stream.
  - Per word: bit i uses state for indices < 0; bits are processed in order 0..W_DATA-1.
  - The state shifts in the W_DATA scrambled input bits on every cycle with i_grbx_data_valid=1, regardless of FSM state or i_rx_lock.
  - The state is frozen when data_valid=0.
  - The header never enters the descrambler.
- FSM states:
  - IDLE: no header held.
    - data_valid: the word is descrambled and discarded.
    - hdr_valid: capture header -> COLLECT with index=0.
  - COLLECT: each data_valid word is written to payload slice [index*W_DATA +: W_DATA] and index increments.
    - When the last word (index=WORDS_PER_BLK-1) is written -> EMIT.
  - EMIT: registered outputs drive o_blk_valid=1 for one cycle.
    - If hdr_valid arrived in the same cycle as the last word -> COLLECT with the new header; otherwise -> IDLE.
- Simultaneous hdr_valid and data_valid in one cycle:
  - The data word is applied to the current block first.
  - The header is then captured for the following block.
- hdr_valid in COLLECT with index>0 and the block not completed by this cycle's word:
  - Drop the partial payload.
  - Pulse o_align_err for 1 cycle.
  - Capture the new header and restart at index=0.
- hdr_valid in COLLECT with index=0: overwrite the header; no error.
- i_rx_lock=0:
  - FSM forced to IDLE next cycle; index cleared; no o_blk_valid.
  - No o_align_err is generated while unlocked.
  - Descrambler keeps running.
- Latency: o_blk_valid asserts exactly 1 cycle after the cycle accepting the final data word.
- Hold behaviour:
  - o_blk_hdr, o_blk_data and o_blk_hdr_err hold their last values between pulses.
  - o_blk_hdr_err is computed combinationally from the captured header and registered with the block.
- Throughput: one block per WORDS_PER_BLK data_valid cycles. Data_valid gaps (gearbox skip cycles) stall assembly without error.
- Reset mid-block: partial block discarded silently and descrambler state zeroed. The first block out after reset may be corrupt (58-bit sync-in); this is not flagged.

Decomposition:
- Shared package eth_pcs_params:
  - W_BLK, WORDS_PER_BLK.
  - SCR_TAP_A=39, SCR_TAP_B=58.
  - Sync header constants HDR_DATA=2'b10 and HDR_CTRL=2'b01 (bit0 first).
  - FSM state enum.
- Sub-module eth_pcs_descrambler_core:
  - Parameterised W_DATA.
  - Ports: i_clk, i_reset, i_valid, i_data, o_data (combinational).
  - Owns the 58b state register.
  - Reused by the TX scrambler test model.

Test Plan:
- Reset, lock=1, hdr 2'b10, then two words 0xFFFFFFFF, 0xFFFFFFFF -> o_blk_valid one cycle after 2nd word; o_blk_data=0xFC00007F_FFFFFFFF, o_blk_hdr=2'b10, o_blk_hdr_err=0.
- Header 2'b11 with two zero words after reset -> o_blk_data=0, o_blk_hdr_err=1.
- hdr_valid after only one data word -> o_align_err pulse, no o_blk_valid; the next two words form a block with the new header.
- Back-to-back blocks with hdr_valid coincident with the last word of the previous block, plus one data_valid=0 gap inside a block -> consecutive o_blk_valid pulses, correct headers, no o_align_err.
- Drop i_rx_lock mid-block for 3 cycles while feeding words -> no valid and no align_err. After relock, blocks resume at the next hdr_valid, and payload matches a golden serial descrambler fed all words including those sent while unlocked.
- Random scrambled traffic from a reference cl.49 scrambler (seed 0x3FF_FFFF_FFFF_FFFF) over 1000 blocks -> payload matches the original from block 1 onward; block 0 is excluded.

Source files
------------

// File: rtl/eth_pcs_params_pkg.sv
// Shared constants, types and helpers for the PCS RX block path.
// Sync headers are written bit0-first, matching the gearbox bit order.
package eth_pcs_params;

    localparam int W_SYNC        = 2;
    localparam int W_BLK         = 64;
    localparam int W_DATA_DFLT   = 32;
    localparam int WORDS_PER_BLK = W_BLK / W_DATA_DFLT;

    localparam int SCR_TAP_A = 39;
    localparam int SCR_TAP_B = 58;

    localparam logic [W_SYNC-1:0] HDR_DATA = 2'b10;
    localparam logic [W_SYNC-1:0] HDR_CTRL = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } rx_state_e;

    function automatic logic hdr_is_bad(input logic [W_SYNC-1:0] hdr);
        return !((hdr == HDR_DATA) || (hdr == HDR_CTRL));
    endfunction

endpackage

// File: rtl/eth_pcs_descrambler_core.sv
// Self-synchronous 1 + x^39 + x^58 descrambler, W_DATA bits per valid cycle.
// Output is combinational from the current word and the stored history.
module eth_pcs_descrambler_core
    import eth_pcs_params::*;
#(
    parameter int W_DATA = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [W_DATA-1:0] i_data,
    output logic [W_DATA-1:0] o_data
);

    // r_state[SCR_TAP_B-1] is the most recently received scrambled bit.
    logic [SCR_TAP_B-1:0]        r_state;
    logic [W_DATA+SCR_TAP_B-1:0] w_hist;

    assign w_hist = {i_data, r_state};

    always_comb begin
        o_data = '0;
        for (int j = 0; j < W_DATA; j++) begin
            o_data[j] = w_hist[SCR_TAP_B + j]
                      ^ w_hist[SCR_TAP_B - SCR_TAP_A + j]
                      ^ w_hist[j];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= '0;
        end else if (i_valid) begin
            r_state <= w_hist[W_DATA+SCR_TAP_B-1 -: SCR_TAP_B];
        end
    end

endmodule

// File: rtl/eth_pcs_rx_descrambler.sv
// Descrambles gearbox payload words and reassembles them with their sync
// header into 66b blocks, flagging bad headers and block misalignment.
module eth_pcs_rx_descrambler
    import eth_pcs_params::*;
#(
    parameter int W_DATA = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx_lock,
    input  logic              i_grbx_hdr_valid,
    input  logic [W_SYNC-1:0] i_grbx_hdr,
    input  logic              i_grbx_data_valid,
    input  logic [W_DATA-1:0] i_grbx_data,
    output logic              o_blk_valid,
    output logic [W_SYNC-1:0] o_blk_hdr,
    output logic [W_BLK-1:0]  o_blk_data,
    output logic              o_blk_hdr_err,
    output logic              o_align_err,
    output rx_state_e         o_dbg_state
);

    localparam int WPB   = W_BLK / W_DATA;
    localparam int W_IDX = (WPB > 1) ? $clog2(WPB) : 1;
    localparam logic [W_IDX-1:0] LAST_IDX = W_IDX'(WPB - 1);

    rx_state_e         r_state;
    logic [W_IDX-1:0]  r_idx;
    logic [W_SYNC-1:0] r_hdr;
    logic              r_pend;
    logic [W_BLK-1:0]  r_payload;

    logic [W_DATA-1:0] w_desc;
    logic [W_BLK-1:0]  w_payload;
    logic              w_collecting;
    logic              w_last;

    eth_pcs_descrambler_core #(.W_DATA(W_DATA)) u_core (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_grbx_data_valid),
        .i_data  (i_grbx_data),
        .o_data  (w_desc)
    );

    // EMIT with a header captured alongside the last word already owns the next block.
    assign w_collecting = (r_state == ST_COLLECT) || ((r_state == ST_EMIT) && r_pend);
    assign w_last       = w_collecting && i_grbx_data_valid && (r_idx == LAST_IDX);
    assign o_dbg_state  = r_state;

    always_comb begin
        w_payload = r_payload;
        w_payload[r_idx*W_DATA +: W_DATA] = w_desc;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_hdr         <= '0;
            r_pend        <= 1'b0;
            r_payload     <= '0;
            o_blk_valid   <= 1'b0;
            o_blk_hdr     <= '0;
            o_blk_data    <= '0;
            o_blk_hdr_err <= 1'b0;
            o_align_err   <= 1'b0;
        end else begin
            o_blk_valid <= 1'b0;
            o_align_err <= 1'b0;
            if (!i_rx_lock) begin
                r_state <= ST_IDLE;
                r_idx   <= '0;
                r_pend  <= 1'b0;
            end else if (w_collecting) begin
                if (i_grbx_data_valid) begin
                    r_payload <= w_payload;
                end
                if (w_last) begin
                    o_blk_valid   <= 1'b1;
                    o_blk_hdr     <= r_hdr;
                    o_blk_data    <= w_payload;
                    o_blk_hdr_err <= hdr_is_bad(r_hdr);
                    r_state       <= ST_EMIT;
                    r_pend        <= i_grbx_hdr_valid;
                    r_idx         <= '0;
                    if (i_grbx_hdr_valid) begin
                        r_hdr <= i_grbx_hdr;
                    end
                end else if (i_grbx_hdr_valid) begin
                    // A header before the block completes means we lost alignment.
                    o_align_err <= (r_idx != '0);
                    r_hdr       <= i_grbx_hdr;
                    r_idx       <= '0;
                    r_state     <= ST_COLLECT;
                    r_pend      <= 1'b0;
                end else begin
                    if (i_grbx_data_valid) begin
                        r_idx <= r_idx + 1'b1;
                    end
                    r_state <= ST_COLLECT;
                    r_pend  <= 1'b0;
                end
            end else begin
                r_pend <= 1'b0;
                r_idx  <= '0;
                if (i_grbx_hdr_valid) begin
                    r_hdr   <= i_grbx_hdr;
                    r_state <= ST_COLLECT;
                end else begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

endmodule
